// File: rtl/tx_module.sv
// UART transmit engine: serialises one 5..8 data-bit frame with optional even parity and 1..4 stop bits.
// Optional line-break support is compiled in when TX_BREAK_EN is defined.
module tx_module #(
    parameter int MAX_DATA_WIDTH       = 8,
    parameter int DATA_COUNTER_WIDTH   = 3,
    parameter int STOP_CONF_WIDTH      = 2,
    parameter int DATA_CONF_WIDTH      = 2,
    parameter int SAMPLE_COUNTER_WIDTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      baud_en_i,
    input  logic                      tx_en_i,
    input  logic                      tx_start_i,
    input  logic [MAX_DATA_WIDTH-1:0] tx_data_i,
    input  logic [DATA_CONF_WIDTH+STOP_CONF_WIDTH:0] tx_conf_i,
`ifdef TX_BREAK_EN
    input  logic                      tx_break_i,
`endif
    output logic                      uart_tx_o,
    output logic                      busy_o,
    output logic                      tx_done_o
);

    localparam int CONF_W = DATA_CONF_WIDTH + STOP_CONF_WIDTH + 1;
    localparam logic [SAMPLE_COUNTER_WIDTH-1:0] TICK_ONE = {{(SAMPLE_COUNTER_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_COUNTER_WIDTH-1:0]   BIT_ONE  = {{(DATA_COUNTER_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [STOP_CONF_WIDTH-1:0]      STOP_ONE = {{(STOP_CONF_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        ST_RESET  = 4'd0,
        ST_IDLE   = 4'd1,
        ST_START  = 4'd2,
        ST_DATA   = 4'd3,
        ST_PARITY = 4'd4,
        ST_STOP   = 4'd5,
        ST_DONE   = 4'd6,
        ST_BREAK  = 4'd7,
        ST_GUARD  = 4'd8
    } state_t;

    state_t                            state_q, state_d;
    logic [SAMPLE_COUNTER_WIDTH-1:0]   tick_q, tick_d;
    logic [DATA_COUNTER_WIDTH-1:0]     bit_q, bit_d;
    logic [STOP_CONF_WIDTH-1:0]        stop_q, stop_d;
    logic [MAX_DATA_WIDTH-1:0]         data_q, data_d;
    logic [CONF_W-1:0]                 conf_q, conf_d;
    logic                              tx_q, tx_d;
    logic                              busy_q, busy_d;
    logic                              done_q, done_d;

    logic                              bit_end_s;
    logic                              break_s;
    logic [DATA_COUNTER_WIDTH-1:0]     last_idx_s;
    logic [DATA_COUNTER_WIDTH-1:0]     next_bit_s;

    // Even parity over the data bits that are actually transmitted.
    function automatic logic parity_of(input logic [MAX_DATA_WIDTH-1:0] data,
                                       input logic [DATA_COUNTER_WIDTH-1:0] last_idx);
        logic p;
        p = 1'b0;
        for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
            p = p ^ (data[i] & (DATA_COUNTER_WIDTH'(i) <= last_idx));
        end
        return p;
    endfunction

`ifdef TX_BREAK_EN
    assign break_s = tx_break_i;
`else
    assign break_s = 1'b0;
`endif

    assign bit_end_s  = baud_en_i && (tick_q == {SAMPLE_COUNTER_WIDTH{1'b1}});
    assign last_idx_s = DATA_COUNTER_WIDTH'(3'd4) + DATA_COUNTER_WIDTH'(conf_q[CONF_W-1 -: DATA_CONF_WIDTH]);
    assign next_bit_s = bit_q + BIT_ONE;

    // Next-state and output logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        data_d  = data_q;
        conf_d  = conf_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_RESET: begin
                if (break_s) begin
                    state_d = ST_BREAK;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end else if (baud_en_i && tx_en_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESET;
                end
            end
            ST_IDLE: begin
                if (break_s) begin
                    state_d = ST_BREAK;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end else if (tx_start_i && tx_en_i) begin
                    // Acceptance is not paced by the baud tick: start bit begins now.
                    data_d  = tx_data_i;
                    conf_d  = tx_conf_i;
                    busy_d  = 1'b1;
                    tx_d    = 1'b0;
                    tick_d  = {SAMPLE_COUNTER_WIDTH{1'b0}};
                    state_d = ST_START;
                end else if (baud_en_i && !tx_en_i) begin
                    state_d = ST_RESET;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_en_i) begin
                    tick_d = tick_q + TICK_ONE;
                end else begin
                    tick_d = tick_q;
                end
                if (bit_end_s) begin
                    state_d = ST_DATA;
                    bit_d   = {DATA_COUNTER_WIDTH{1'b0}};
                    tx_d    = data_q[0];
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (baud_en_i) begin
                    tick_d = tick_q + TICK_ONE;
                end else begin
                    tick_d = tick_q;
                end
                if (bit_end_s && (bit_q == last_idx_s)) begin
                    if (conf_q[0]) begin
                        state_d = ST_PARITY;
                        tx_d    = parity_of(data_q, last_idx_s);
                    end else begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                        stop_d  = {STOP_CONF_WIDTH{1'b0}};
                    end
                end else if (bit_end_s) begin
                    bit_d = next_bit_s;
                    tx_d  = data_q[next_bit_s];
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (baud_en_i) begin
                    tick_d = tick_q + TICK_ONE;
                end else begin
                    tick_d = tick_q;
                end
                if (bit_end_s) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                    stop_d  = {STOP_CONF_WIDTH{1'b0}};
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (baud_en_i) begin
                    tick_d = tick_q + TICK_ONE;
                end else begin
                    tick_d = tick_q;
                end
                if (bit_end_s && (stop_q == conf_q[STOP_CONF_WIDTH:1])) begin
                    state_d = ST_DONE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (bit_end_s) begin
                    stop_d = stop_q + STOP_ONE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_DONE: begin
                bit_d  = {DATA_COUNTER_WIDTH{1'b0}};
                stop_d = {STOP_CONF_WIDTH{1'b0}};
                if (baud_en_i) begin
                    state_d = tx_en_i ? ST_IDLE : ST_RESET;
                end else begin
                    state_d = ST_DONE;
                end
            end
`ifdef TX_BREAK_EN
            ST_BREAK: begin
                if (!break_s) begin
                    state_d = ST_GUARD;
                    tx_d    = 1'b1;
                    tick_d  = {SAMPLE_COUNTER_WIDTH{1'b0}};
                end else begin
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_GUARD: begin
                // Line is held idle-high for one full bit time after a break.
                if (baud_en_i) begin
                    tick_d = tick_q + TICK_ONE;
                end else begin
                    tick_d = tick_q;
                end
                if (bit_end_s) begin
                    state_d = tx_en_i ? ST_IDLE : ST_RESET;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_GUARD;
                end
            end
`endif
            default: begin
                state_d = ST_RESET;
                tick_d  = {SAMPLE_COUNTER_WIDTH{1'b0}};
                bit_d   = {DATA_COUNTER_WIDTH{1'b0}};
                stop_d  = {STOP_CONF_WIDTH{1'b0}};
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RESET;
            tick_q  <= {SAMPLE_COUNTER_WIDTH{1'b0}};
            bit_q   <= {DATA_COUNTER_WIDTH{1'b0}};
            stop_q  <= {STOP_CONF_WIDTH{1'b0}};
            data_q  <= {MAX_DATA_WIDTH{1'b0}};
            conf_q  <= {CONF_W{1'b0}};
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            data_q  <= data_d;
            conf_q  <= conf_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign uart_tx_o = tx_q;
    assign busy_o    = busy_q;
    assign tx_done_o = done_q;

endmodule
